// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - two-requester (JTAG, core) round-robin arbiter onto one L2 port
// Tracks granted-but-unanswered transactions in an in-order ID FIFO and routes responses back.
module l2_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [1:0]                req_i,
  output logic [1:0]                gnt_o,
  input  logic [2*ADDR_WIDTH-1:0]   addr_i,
  input  logic [1:0]                we_i,
  input  logic [2*DATA_WIDTH/8-1:0] be_i,
  input  logic [2*DATA_WIDTH-1:0]   wdata_i,
  output logic [1:0]                rvalid_o,
  output logic [2*DATA_WIDTH-1:0]   rdata_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      spurious_rsp_o
);

  localparam int         BW       = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTST);
  localparam logic [1:0] LAST_PTR = 2'(MAX_OUTST - 1);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e                       state_q, state_d;
  logic                         lock_sel_q, lock_sel_d;
  logic                         last_q, last_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [1:0]                   wr_ptr_q, wr_ptr_d;
  logic [1:0]                   rd_ptr_q, rd_ptr_d;
  logic [3:0]                   id_q, id_d;
  logic [1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                         spurious_q, spurious_d;

  logic                         sel;
  logic                         slot_free;
  logic                         push;
  logic                         pop;
  logic                         head;
  logic [1:0][DATA_WIDTH-1:0]   rdata_mux;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // State register for the grant-lock FSM and all datapath state
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_q       <= '0;
      rdata_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      id_q       <= id_d;
      rdata_q    <= rdata_d;
      spurious_q <= spurious_d;
    end
  end

  // Next-state: hold the selection while a presented request waits for its grant
  always_comb begin
    state_d    = IDLE;
    lock_sel_d = lock_sel_q;
    if (mem_req_o && !mem_gnt_i) begin
      state_d    = WAIT_GNT;
      lock_sel_d = sel;
    end
  end

  // Outputs: selection and L2 command; mem_req_o looks only at registered count
  always_comb begin
    sel = ~last_q;
    if (state_q == WAIT_GNT && req_i[lock_sel_q]) begin
      sel = lock_sel_q;
    end else if (req_i == 2'b01) begin
      sel = 1'b0;
    end else if (req_i == 2'b10) begin
      sel = 1'b1;
    end
    slot_free   = (cnt_q < MAX_CNT);
    mem_req_o   = rst_n & req_i[sel] & slot_free;
    gnt_o       = 2'b00;
    gnt_o[sel]  = mem_req_o & mem_gnt_i;
    mem_addr_o  = sel ? addr_i[ADDR_WIDTH +: ADDR_WIDTH] : addr_i[0 +: ADDR_WIDTH];
    mem_we_o    = we_i[sel];
    mem_be_o    = sel ? be_i[BW +: BW] : be_i[0 +: BW];
    mem_wdata_o = sel ? wdata_i[DATA_WIDTH +: DATA_WIDTH] : wdata_i[0 +: DATA_WIDTH];
  end

  // ID FIFO bookkeeping and response routing
  always_comb begin
    push       = mem_req_o & mem_gnt_i;
    pop        = mem_rvalid_i & (cnt_q != 3'd0);
    head       = id_q[rd_ptr_q];
    cnt_d      = cnt_q + 3'(push) - 3'(pop);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    id_d       = id_q;
    if (push) begin
      id_d[wr_ptr_q] = sel;
    end
    last_d     = push ? sel : last_q;
    spurious_d = spurious_q | (mem_rvalid_i & (cnt_q == 3'd0));

    rvalid_o   = 2'b00;
    rdata_mux  = rdata_q;
    if (pop) begin
      rvalid_o[head]  = 1'b1;
      rdata_mux[head] = mem_rdata_i;
    end
    rdata_d        = rdata_mux;
    rdata_o        = rdata_mux;
    spurious_rsp_o = spurious_q;
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed scenarios plus randomized run against a queue-based model
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic            clk_i = 1'b0;
  logic            rst_n;
  logic [1:0]      req_i;
  logic [1:0]      gnt_o;
  logic [2*AW-1:0] addr_i;
  logic [1:0]      we_i;
  logic [2*BW-1:0] be_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      rvalid_o;
  logic [2*DW-1:0] rdata_o;
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_we_o;
  logic [BW-1:0]   mem_be_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            spurious_rsp_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .spurious_rsp_o(spurious_rsp_o)
  );

  function automatic logic [DW-1:0] rd(input int k);
    return rdata_o[k*DW +: DW];
  endfunction

  task automatic idle_inputs();
    req_i = 2'b00; we_i = 2'b00; addr_i = '0; be_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (mem_req_o !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00 ||
          rdata_o !== '0 || spurious_rsp_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: req=%b gnt=%b rvalid=%b rdata=%h spur=%b, required all zero",
                 i, mem_req_o, gnt_o, rvalid_o, rdata_o, spurious_rsp_o);
      end
      @(posedge clk_i);
    end
    #1 idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_jtag_write_read();
    int core_rv = 0;
    apply_reset();
    next_cycle();
    req_i = 2'b01; we_i = 2'b01; addr_i[0 +: AW] = 32'h0; be_i[0 +: BW] = 4'hF;
    wdata_i[0 +: DW] = 32'hABBA_ABBA; mem_gnt_i = 1'b1;
    #3;
    n_tests++;
    if (gnt_o !== 2'b01 || mem_addr_o !== 32'h0 || mem_we_o !== 1'b1 ||
        mem_be_o !== 4'hF || mem_wdata_o !== 32'hABBA_ABBA) begin
      n_fail++;
      $display("FAIL jtag_write_cmd: gnt=%b addr=%h we=%b be=%h wdata=%h, required 01/0/1/f/abbaabba",
               gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
    end
    core_rv += rvalid_o[1];
    next_cycle();
    req_i = 2'b01; we_i = 2'b00; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #3;
    n_tests++;
    if (gnt_o !== 2'b01 || mem_we_o !== 1'b0 || rvalid_o !== 2'b01) begin
      n_fail++;
      $display("FAIL jtag_read_cmd: gnt=%b we=%b rvalid=%b, required 01/0/01", gnt_o, mem_we_o, rvalid_o);
    end
    core_rv += rvalid_o[1];
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABBA_ABBA;
    #3;
    n_tests++;
    if (rvalid_o !== 2'b01 || rd(0) !== 32'hABBA_ABBA) begin
      n_fail++;
      $display("FAIL jtag_read_rsp: rvalid=%b rdata0=%h, required 01/abbaabba", rvalid_o, rd(0));
    end
    core_rv += rvalid_o[1];
    next_cycle();
    mem_rdata_i = 32'h1234_5678;
    #3;
    n_tests++;
    if (rvalid_o !== 2'b00 || rd(0) !== 32'hABBA_ABBA || core_rv != 0) begin
      n_fail++;
      $display("FAIL jtag_rdata_hold: rvalid=%b rdata0=%h core_rvalids=%0d, required 00/abbaabba/0",
               rvalid_o, rd(0), core_rv);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    apply_reset();
    prev_g = 2'b00;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = (c > 0);
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      #3;
      n_tests++;
      if (gnt_o !== exp_g || rvalid_o !== prev_g) begin
        n_fail++;
        $display("FAIL alternate[%0d]: gnt=%b rvalid=%b, required gnt=%b rvalid=%b",
                 c, gnt_o, rvalid_o, exp_g, prev_g);
      end
      prev_g = exp_g;
    end
  endtask

  task automatic test_lock();
    logic [AW-1:0] exp_a;
    logic [1:0]    exp_g;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      addr_i = {32'h0000_0200, 32'h0000_0100};
      req_i = (c == 0) ? 2'b10 : 2'b11;
      mem_gnt_i = (c >= 3);
      exp_a = (c == 4) ? 32'h100 : 32'h200;
      exp_g = (c == 3) ? 2'b10 : ((c == 4) ? 2'b01 : 2'b00);
      #3;
      n_tests++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== exp_a || gnt_o !== exp_g) begin
        n_fail++;
        $display("FAIL lock[%0d]: req=%b addr=%h gnt=%b, required 1/%h/%b",
                 c, mem_req_o, mem_addr_o, gnt_o, exp_a, exp_g);
      end
    end
  endtask

  task automatic test_max_outst();
    logic       exp_r [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_g [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
    logic [1:0] exp_v [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      req_i = 2'b11; mem_gnt_i = 1'b1;
      mem_rvalid_i = (c == 3); mem_rdata_i = 32'h0000_0055;
      #3;
      n_tests++;
      if (mem_req_o !== exp_r[c] || gnt_o !== exp_g[c] || rvalid_o !== exp_v[c] ||
          (c == 3 && rd(0) !== 32'h55)) begin
        n_fail++;
        $display("FAIL max_outst[%0d]: req=%b gnt=%b rvalid=%b rdata0=%h, required %b/%b/%b",
                 c, mem_req_o, gnt_o, rvalid_o, rd(0), exp_r[c], exp_g[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_interleave();
    apply_reset();
    next_cycle();
    req_i = 2'b01; addr_i[0 +: AW] = 32'h10; mem_gnt_i = 1'b1;
    #3;
    n_tests++;
    if (gnt_o !== 2'b01 || mem_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL interleave_jtag_cmd: gnt=%b addr=%h, required 01/10", gnt_o, mem_addr_o);
    end
    next_cycle();
    req_i = 2'b10; addr_i[AW +: AW] = 32'h20; mem_gnt_i = 1'b1;
    #3;
    n_tests++;
    if (gnt_o !== 2'b10 || mem_addr_o !== 32'h20) begin
      n_fail++;
      $display("FAIL interleave_core_cmd: gnt=%b addr=%h, required 10/20", gnt_o, mem_addr_o);
    end
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    #3;
    n_tests++;
    if (rvalid_o !== 2'b01 || rd(0) !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL interleave_rsp0: rvalid=%b rdata0=%h, required 01/11111111", rvalid_o, rd(0));
    end
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2222_2222;
    #3;
    n_tests++;
    if (rvalid_o !== 2'b10 || rd(1) !== 32'h2222_2222 || rd(0) !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL interleave_rsp1: rvalid=%b rdata1=%h rdata0=%h, required 10/22222222/11111111",
               rvalid_o, rd(1), rd(0));
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    next_cycle();
    req_i = 2'b01; mem_gnt_i = 1'b1;
    apply_reset();
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #3;
    n_tests++;
    if (rvalid_o !== 2'b00 || spurious_rsp_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_drop: rvalid=%b spur=%b, required 00/0", rvalid_o, spurious_rsp_o);
    end
    next_cycle();
    #3;
    n_tests++;
    if (spurious_rsp_o !== 1'b1 || rvalid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_set: spur=%b rvalid=%b, required 1/00", spurious_rsp_o, rvalid_o);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (spurious_rsp_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_clear: spur=%b, required 0", spurious_rsp_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit            q[$];
    bit            last = 1'b1;
    bit            pend_v = 1'b0;
    bit            pend_id = 1'b0;
    bit            spur = 1'b0;
    bit            s;
    bit            e_req;
    bit            e_pop;
    logic [1:0]    e_gnt;
    logic [1:0]    e_rv;
    logic [DW-1:0] last_rd [2];
    int            size0;
    apply_reset();
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      req_i = 2'($urandom_range(0, 3));
      we_i = 2'($urandom_range(0, 3));
      addr_i = {$urandom, $urandom};
      be_i = 8'($urandom);
      wdata_i = {$urandom, $urandom};
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i = $urandom;

      size0 = q.size();
      if (pend_v && req_i[pend_id]) s = pend_id;
      else if (req_i == 2'b11) s = !last;
      else if (req_i[0]) s = 1'b0;
      else s = 1'b1;
      e_req = req_i[s] && (size0 < MO);
      e_gnt = (e_req && mem_gnt_i) ? (s ? 2'b10 : 2'b01) : 2'b00;
      e_pop = mem_rvalid_i && (size0 > 0);
      e_rv = 2'b00;
      if (e_pop) begin
        e_rv = q[0] ? 2'b10 : 2'b01;
        last_rd[q[0]] = mem_rdata_i;
      end
      #3;
      n_tests++;
      if (mem_req_o !== e_req || gnt_o !== e_gnt || rvalid_o !== e_rv ||
          rd(0) !== last_rd[0] || rd(1) !== last_rd[1] || spurious_rsp_o !== spur ||
          (e_req && (mem_addr_o !== addr_i[s*AW +: AW] || mem_we_o !== we_i[s] ||
                     mem_wdata_o !== wdata_i[s*DW +: DW] || mem_be_o !== be_i[s*BW +: BW]))) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b gnt=%b rv=%b rd0=%h rd1=%h spur=%b addr=%h, required %b/%b/%b/%h/%h/%b/%h",
                 c, mem_req_o, gnt_o, rvalid_o, rd(0), rd(1), spurious_rsp_o, mem_addr_o,
                 e_req, e_gnt, e_rv, last_rd[0], last_rd[1], spur, addr_i[s*AW +: AW]);
      end
      if (e_pop) void'(q.pop_front());
      if (e_req && mem_gnt_i) begin
        q.push_back(s);
        last = s;
      end
      pend_v = e_req && !mem_gnt_i;
      pend_id = s;
      if (mem_rvalid_i && size0 == 0) spur = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_jtag_write_read();
    test_alternate();
    test_lock();
    test_max_outst();
    test_interleave();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
